mire_sequencer: RTL



---
 rtl/mire_pkg.sv | 32 +++
 rtl/frame_edge.sv | 47 ++++
 rtl/mire_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mire_pkg.sv
// mire_pkg: shared types and constants for the test-pattern (mire) sequencer
// and the background generators it drives.
//   mire_state_t : sequencer operating mode (MANUAL, AUTO, FREEZE)
//   band_t       : colour band rotation, 0..NBANDS-1
//   pat_t        : pattern generator select, 0..NPAT-1
//   DEF_HACTIVE / DEF_VACTIVE : default active raster shared with the generators
package mire_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    FREEZE = 2'd2
  } mire_state_t;

  localparam int NBANDS      = 6;
  localparam int DEF_HACTIVE = 800;
  localparam int DEF_VACTIVE = 600;

  typedef logic [2:0] band_t;
  typedef logic [1:0] pat_t;

  // Band rotation wraps after the last of the six bands.
  function automatic band_t next_band(input band_t b);
    return (b == band_t'(NBANDS - 1)) ? '0 : b + band_t'(1);
  endfunction

  // Pattern select wraps after the last populated generator.
  function automatic pat_t next_pat(input pat_t p, input int npat);
    return (p == pat_t'(npat - 1)) ? '0 : p + pat_t'(1);
  endfunction

endpackage

// File: rtl/frame_edge.sv
// frame_edge: end-of-active-frame detector and frame counter.
//   clk, reset_n  : pixel clock, synchronous active-low reset
//   spotX, spotY  : signed raster position from the video timing block
//   eof_set       : combinational "first cycle at last active pixel"; the
//                   registers that must change together with eof use it
//   eof           : registered one-cycle pulse, end of active frame
//   frame_cnt     : frames since reset, wraps 65535 -> 0, steps with eof
module frame_edge
  import mire_pkg::*;
#(
  parameter int HACTIVE = DEF_HACTIVE,
  parameter int VACTIVE = DEF_VACTIVE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [10:0] spotX,
  input  logic signed [10:0] spotY,
  output logic               eof_set,
  output logic               eof,
  output logic [15:0]        frame_cnt
);

  localparam logic signed [10:0] X_LAST = 11'(HACTIVE - 1);
  localparam logic signed [10:0] Y_LAST = 11'(VACTIVE - 1);

  logic raw;
  logic raw_q;

  // Signed compare: blanking coordinates are negative and never match.
  assign raw = (spotX == X_LAST) && (spotY == Y_LAST);

  // Only the first cycle of a (possibly stalled) last-pixel position counts.
  assign eof_set = raw && !raw_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      raw_q     <= 1'b0;
      eof       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      raw_q <= raw;
      eof   <= eof_set;
      if (eof_set) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mire_sequencer.sv
// mire_sequencer: frame-synchronous scheduler for the mire background
// generators. Selects the pattern generator and the rotation of its six
// colour bands, advancing every DWELL_FRAMES frames (auto) or once per
// manual step. All changes land on the end-of-frame edge only.
//   clk, reset_n     : pixel clock, synchronous active-low reset
//   spotX, spotY     : signed raster position
//   auto_en, freeze  : mode levels, freeze has highest priority
//   step             : single-cycle manual advance request
//   pattern_sel      : selected generator 0..NPAT-1
//   band_rot         : band rotation 0..5
//   eof, frame_cnt   : end-of-frame pulse and frame counter
//   busy_step        : a manual step is pending
//   mode             : current operating mode (observability)
//
// Step handshake: step is a one-cycle request with no ready; busy_step rises
// the cycle after the first request and falls on the eof edge that applies
// it. Further requests while busy_step=1 merge into the pending one; a request
// on the applying eof edge re-arms busy_step for the following frame.
module mire_sequencer
  import mire_pkg::*;
#(
  parameter int HACTIVE      = DEF_HACTIVE,
  parameter int VACTIVE      = DEF_VACTIVE,
  parameter int DWELL_FRAMES = 60,
  parameter int NPAT         = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [10:0] spotX,
  input  logic signed [10:0] spotY,
  input  logic               auto_en,
  input  logic               freeze,
  input  logic               step,
  output pat_t               pattern_sel,
  output band_t              band_rot,
  output logic               eof,
  output logic [15:0]        frame_cnt,
  output logic               busy_step,
  output mire_state_t        mode
);

  localparam int DWW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_FRAMES - 1);

  logic eof_set;

  frame_edge #(
    .HACTIVE (HACTIVE),
    .VACTIVE (VACTIVE)
  ) u_frame_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .spotX     (spotX),
    .spotY     (spotY),
    .eof_set   (eof_set),
    .eof       (eof),
    .frame_cnt (frame_cnt)
  );

  mire_state_t    state_q, state_d;
  logic           busy_q, busy_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  band_t          band_q, band_d;
  pat_t           pat_q, pat_d;
  logic           do_adv;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= MANUAL;
      busy_q  <= 1'b0;
      dwell_q <= '0;
      band_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      dwell_q <= dwell_d;
      band_q  <= band_d;
      pat_q   <= pat_d;
    end
  end

  // Actions use the current (registered) mode, so a mode change that
  // coincides with eof is seen only from the next cycle on.
  always_comb begin
    state_d = freeze ? FREEZE : (auto_en ? AUTO : MANUAL);
    busy_d  = busy_q;
    dwell_d = dwell_q;
    band_d  = band_q;
    pat_d   = pat_q;
    do_adv  = 1'b0;

    unique case (state_q)
      MANUAL: begin
        if (eof_set && busy_q) begin
          do_adv = 1'b1;
          busy_d = step;
        end else if (step) begin
          busy_d = 1'b1;
        end
        if (state_d == AUTO) begin
          dwell_d = '0;
          busy_d  = 1'b0;
        end
      end
      AUTO: begin
        if (eof_set) begin
          if (dwell_q == DWELL_LAST) begin
            do_adv  = 1'b1;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DWW'(1);
          end
        end
      end
      default: ;
    endcase

    if (do_adv) begin
      band_d = next_band(band_q);
      if (band_q == band_t'(NBANDS - 1)) pat_d = next_pat(pat_q, NPAT);
    end
  end

  assign pattern_sel = pat_q;
  assign band_rot    = band_q;
  assign busy_step   = busy_q;
  assign mode        = state_q;

endmodule
